// File: rtl/pio_keyboard_debounced.sv
// Avalon-MM input PIO for keypad/switch lines. Each bit passes through a
// two-flop synchroniser and a debounce filter. Debounced transitions are
// latched in a sticky edge-capture register, and that register is masked
// into a single level interrupt.
module pio_keyboard_debounced #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0      // 0 rising, 1 falling, 2 any
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             write_en;
  logic             unused_writedata;

  // Upper writedata bits are not stored when WIDTH < 32.
  assign unused_writedata = &{1'b0, writedata};

  assign write_en = chipselect & ~write_n;

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync2_next_unused_guard(sync1_reg);
    end
  end

  // Identity helper; keeps the synchroniser stage explicit and named.
  function automatic logic [WIDTH-1:0] sync2_next_unused_guard(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  // Per-bit debounce counters. A bit is accepted when the synchronised level
  // has differed from the debounced level for DEBOUNCE_CYCLES consecutive
  // cycles; any return to the debounced level restarts the count.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;

      assign accept[gi] = (sync2_reg[gi] != stable_reg[gi]) && (cnt_reg == CNT_LAST);

      // Count consecutive cycles of disagreement, clearing on agreement or accept.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if ((sync2_reg[gi] == stable_reg[gi]) || accept[gi]) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Debounced level flips exactly on the bits accepted this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_reg <= '0;
    end else begin
      stable_reg <= stable_reg ^ accept;
    end
  end

  // Select which accepted transitions set edge capture, then merge with the
  // write-1-to-clear so that a simultaneous new edge keeps the bit set.
  always_comb begin
    edge_set = accept & sync2_reg;
    if (EDGE_TYPE == 1) begin
      edge_set = accept & ~sync2_reg;
    end else if (EDGE_TYPE == 2) begin
      edge_set = accept;
    end
    clear_mask = '0;
    if (write_en && (address == 2'd3)) begin
      clear_mask = writedata[WIDTH-1:0];
    end
    edge_capture_next = (edge_capture_reg & ~clear_mask) | edge_set;
  end

  // Interrupt mask and sticky edge-capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_reg     <= '0;
      edge_capture_reg <= '0;
    end else begin
      if (write_en && (address == 2'd1)) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
      edge_capture_reg <= edge_capture_next;
    end
  end

  // Read mux; unused upper bits and the reserved slot read as zero.
  always_comb begin
    readdata_next = '0;
    case (address)
      2'd0:    readdata_next[WIDTH-1:0] = stable_reg;
      2'd1:    readdata_next[WIDTH-1:0] = irq_mask_reg;
      2'd3:    readdata_next[WIDTH-1:0] = edge_capture_reg;
      default: readdata_next = '0;
    endcase
  end

  // Registered read data, refreshed every cycle from the mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= '0;
    end else begin
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule
